// File: rtl/code_breaker_pkg.sv
// Shared mastermind parameters, FSM encoding and history entry layout for the code breaker.
package code_breaker_pkg;

  localparam int unsigned CODE_LEN   = 4;
  localparam int unsigned COLOR_W    = 3;
  localparam int unsigned MAX_TURNS  = 8;
  localparam int unsigned CODE_W     = CODE_LEN * COLOR_W;
  localparam int unsigned NUM_COLORS = 1 << COLOR_W;
  localparam int unsigned TURN_W     = $clog2(MAX_TURNS);
  // Wide enough for a peg count of 0..CODE_LEN.
  localparam int unsigned PEG_W      = 3;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StSearch = 3'd1;
  localparam logic [2:0] StOffer  = 3'd2;
  localparam logic [2:0] StWaitFb = 3'd3;
  localparam logic [2:0] StSolved = 3'd4;
  localparam logic [2:0] StFailed = 3'd5;

  typedef logic [CODE_W-1:0] code_t;

  typedef struct packed {
    code_t            code;
    logic [PEG_W-1:0] black;
    logic [PEG_W-1:0] white;
  } hist_t;

endpackage

// File: rtl/peg_score.sv
// Combinational mastermind scoring: exact-position (black) and colour-only (white) peg counts.
module peg_score
  import code_breaker_pkg::*;
(
  input  logic [CODE_W-1:0] code_a,
  input  logic [CODE_W-1:0] code_b,
  output logic [PEG_W-1:0]  black,
  output logic [PEG_W-1:0]  white
);

  logic [PEG_W-1:0] cnt_a;
  logic [PEG_W-1:0] cnt_b;
  logic [PEG_W-1:0] total;

  always_comb begin
    black = '0;
    total = '0;
    cnt_a = '0;
    cnt_b = '0;
    for (int p = 0; p < CODE_LEN; p++) begin
      if (code_a[p*COLOR_W +: COLOR_W] == code_b[p*COLOR_W +: COLOR_W]) begin
        black = black + PEG_W'(1);
      end
    end
    // Total colour overlap is the sum of per-colour minimum counts.
    for (int c = 0; c < NUM_COLORS; c++) begin
      cnt_a = '0;
      cnt_b = '0;
      for (int p = 0; p < CODE_LEN; p++) begin
        if (code_a[p*COLOR_W +: COLOR_W] == COLOR_W'(c)) cnt_a = cnt_a + PEG_W'(1);
        if (code_b[p*COLOR_W +: COLOR_W] == COLOR_W'(c)) cnt_b = cnt_b + PEG_W'(1);
      end
      total = total + ((cnt_a < cnt_b) ? cnt_a : cnt_b);
    end
    white = total - black;
  end

endmodule

// File: rtl/code_breaker.sv
// Mastermind solver: walks candidates in order, offering the first one consistent with all
// scored history, until it is told four blacks or runs out of turns or candidates.
module code_breaker
  import code_breaker_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  output logic               guess_valid,
  input  logic               guess_ready,
  output logic [COLOR_W-1:0] guess0,
  output logic [COLOR_W-1:0] guess1,
  output logic [COLOR_W-1:0] guess2,
  output logic [COLOR_W-1:0] guess3,
  input  logic               fb_valid,
  input  logic [PEG_W-1:0]   fb_black,
  input  logic [PEG_W-1:0]   fb_white,
  output logic [TURN_W-1:0]  turn,
  output logic               busy,
  output logic               solved,
  output logic               failed
);

  logic [2:0]           state_q, state_d;
  code_t                cand_q, cand_d;
  code_t                guess_q, guess_d;
  logic [TURN_W-1:0]    turn_q, turn_d;
  hist_t                hist_q [MAX_TURNS];
  hist_t                hist_d [MAX_TURNS];
  logic [MAX_TURNS-1:0] hist_vld_q, hist_vld_d;

  logic [PEG_W-1:0]     sc_black [MAX_TURNS];
  logic [PEG_W-1:0]     sc_white [MAX_TURNS];
  logic [MAX_TURNS-1:0] entry_ok;
  logic                 consistent;

  // One scorer per history slot so a candidate is checked against all of them each cycle.
  for (genvar i = 0; i < MAX_TURNS; i++) begin : g_score
    peg_score u_peg_score (
      .code_a (cand_q),
      .code_b (hist_q[i].code),
      .black  (sc_black[i]),
      .white  (sc_white[i])
    );
    assign entry_ok[i] = !hist_vld_q[i] ||
                         ((sc_black[i] == hist_q[i].black) && (sc_white[i] == hist_q[i].white));
  end

  assign consistent = &entry_ok;

  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    guess_d    = guess_q;
    turn_d     = turn_q;
    hist_d     = hist_q;
    hist_vld_d = hist_vld_q;
    if (start) begin
      state_d    = StSearch;
      cand_d     = '0;
      turn_d     = '0;
      hist_vld_d = '0;
    end else begin
      case (state_q)
        StSearch: begin
          if (consistent) begin
            guess_d = cand_q;
            state_d = StOffer;
          end else if (cand_q == '1) begin
            state_d = StFailed;
          end else begin
            cand_d = cand_q + CODE_W'(1);
          end
        end
        StOffer: begin
          if (guess_ready) state_d = StWaitFb;
        end
        StWaitFb: begin
          if (fb_valid) begin
            if (fb_black == PEG_W'(CODE_LEN)) begin
              state_d = StSolved;
            end else begin
              // Illegal feedback is kept as-is; nothing will match it.
              hist_d[turn_q].code  = guess_q;
              hist_d[turn_q].black = fb_black;
              hist_d[turn_q].white = fb_white;
              hist_vld_d[turn_q]   = 1'b1;
              if (turn_q == TURN_W'(MAX_TURNS - 1)) begin
                state_d = StFailed;
              end else begin
                turn_d  = turn_q + TURN_W'(1);
                cand_d  = cand_q + CODE_W'(1);
                state_d = StSearch;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      cand_q     <= '0;
      guess_q    <= '0;
      turn_q     <= '0;
      hist_vld_q <= '0;
      for (int i = 0; i < MAX_TURNS; i++) hist_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      cand_q     <= cand_d;
      guess_q    <= guess_d;
      turn_q     <= turn_d;
      hist_vld_q <= hist_vld_d;
      for (int i = 0; i < MAX_TURNS; i++) hist_q[i] <= hist_d[i];
    end
  end

  assign guess0      = guess_q[0*COLOR_W +: COLOR_W];
  assign guess1      = guess_q[1*COLOR_W +: COLOR_W];
  assign guess2      = guess_q[2*COLOR_W +: COLOR_W];
  assign guess3      = guess_q[3*COLOR_W +: COLOR_W];
  assign guess_valid = (state_q == StOffer);
  assign busy        = (state_q == StSearch) || (state_q == StOffer) || (state_q == StWaitFb);
  assign solved      = (state_q == StSolved);
  assign failed      = (state_q == StFailed);
  assign turn        = turn_q;

endmodule

// File: tb/tb_code_breaker.sv
// Directed bench for code_breaker: reset, handshake, a scored solve, exhaustion, start priority
// and asynchronous reset mid-search.
module tb_code_breaker;
  import code_breaker_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       guess_ready = 1'b0;
  logic       fb_valid = 1'b0;
  logic [2:0] fb_black = '0;
  logic [2:0] fb_white = '0;
  logic       guess_valid, busy, solved, failed;
  logic [2:0] guess0, guess1, guess2, guess3, turn;
  logic [11:0] guess_w;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  code_breaker dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .guess_valid (guess_valid),
    .guess_ready (guess_ready),
    .guess0      (guess0),
    .guess1      (guess1),
    .guess2      (guess2),
    .guess3      (guess3),
    .fb_valid    (fb_valid),
    .fb_black    (fb_black),
    .fb_white    (fb_white),
    .turn        (turn),
    .busy        (busy),
    .solved      (solved),
    .failed      (failed)
  );

  assign guess_w = {guess3, guess2, guess1, guess0};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] mk(input int p0, input int p1, input int p2, input int p3);
    logic [11:0] c;
    c[2:0]  = 3'(p0);
    c[5:3]  = 3'(p1);
    c[8:6]  = 3'(p2);
    c[11:9] = 3'(p3);
    return c;
  endfunction

  // Reference scorer using the mark-and-strike method.
  function automatic void score(input logic [11:0] g, input logic [11:0] s,
                                output int b, output int w);
    logic [2:0] gp [4];
    logic [2:0] sp [4];
    bit gu [4];
    bit su [4];
    b = 0;
    w = 0;
    for (int i = 0; i < 4; i++) begin
      gp[i] = g[3*i +: 3];
      sp[i] = s[3*i +: 3];
      gu[i] = 1'b0;
      su[i] = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      if (gp[i] == sp[i]) begin
        b++;
        gu[i] = 1'b1;
        su[i] = 1'b1;
      end
    end
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (!gu[i] && !su[j] && gp[i] == sp[j]) begin
          w++;
          gu[i] = 1'b1;
          su[j] = 1'b1;
        end
      end
    end
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_offer(input string tag, input int budget);
    int n;
    n = 0;
    while (!guess_valid && n < budget) begin
      tick();
      n++;
    end
    check_eq(tag, 32'(guess_valid), 32'd1);
  endtask

  task automatic accept();
    guess_ready = 1'b1;
    tick();
    guess_ready = 1'b0;
  endtask

  task automatic give_fb(input int b, input int w);
    fb_valid = 1'b1;
    fb_black = 3'(b);
    fb_white = 3'(w);
    tick();
    fb_valid = 1'b0;
    fb_black = '0;
    fb_white = '0;
  endtask

  logic [11:0] exp_g [7];
  logic [11:0] hist_g [8];
  int          hist_b [8];
  int          hist_w [8];

  initial begin
    #900000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [11:0] secret;
    int b, w, n, n_guesses;
    bit ok;

    exp_g[0] = mk(0, 0, 0, 0);
    exp_g[1] = mk(1, 1, 1, 1);
    exp_g[2] = mk(2, 2, 2, 1);
    exp_g[3] = mk(3, 2, 1, 3);
    exp_g[4] = mk(4, 1, 2, 3);
    exp_g[5] = mk(2, 3, 1, 4);
    exp_g[6] = mk(1, 2, 3, 4);
    secret   = mk(1, 2, 3, 4);

    // Reset values
    tick();
    tick();
    check_eq("rst_valid", 32'(guess_valid), 0);
    check_eq("rst_guess", 32'(guess_w), 0);
    check_eq("rst_turn", 32'(turn), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_solved", 32'(solved), 0);
    check_eq("rst_failed", 32'(failed), 0);
    check_eq("rst_state", 32'(dut.state_q), 32'(StIdle));
    reset_n = 1'b1;
    repeat (3) tick();
    check_eq("idle_hold", 32'(dut.state_q), 32'(StIdle));

    // Start with ready high: guess 0000 two cycles after start, then solve on black=4
    guess_ready = 1'b1;
    pulse_start();
    check_eq("s1_busy", 32'(busy), 1);
    check_eq("s1_valid", 32'(guess_valid), 0);
    tick();
    check_eq("s2_valid", 32'(guess_valid), 1);
    check_eq("s2_guess", 32'(guess_w), 32'(exp_g[0]));
    fb_valid = 1'b1;
    fb_black = 3'd4;
    tick();
    fb_valid = 1'b0;
    fb_black = '0;
    guess_ready = 1'b0;
    check_eq("acc_valid_low", 32'(guess_valid), 0);
    check_eq("fb_ignored", 32'(solved), 0);
    check_eq("wait_busy", 32'(busy), 1);
    give_fb(4, 0);
    check_eq("win_solved", 32'(solved), 1);
    check_eq("win_busy", 32'(busy), 0);
    repeat (3) tick();
    check_eq("win_hold", 32'(solved), 1);
    check_eq("win_guess", 32'(guess_w), 32'(exp_g[0]));

    // Full solve against secret 1,2,3,4
    pulse_start();
    check_eq("sec_solved_clr", 32'(solved), 0);
    n_guesses = 0;
    for (int k = 0; k < 8; k++) begin
      wait_offer("sec_offer", 5000);
      if (!guess_valid) break;
      if (k < 7) check_eq($sformatf("sec_guess%0d", k), 32'(guess_w), 32'(exp_g[k]));
      check_eq($sformatf("sec_turn%0d", k), 32'(turn), 32'(k));
      ok = 1'b1;
      for (int j = 0; j < k; j++) begin
        score(guess_w, hist_g[j], b, w);
        if (b != hist_b[j] || w != hist_w[j]) ok = 1'b0;
      end
      check_eq($sformatf("sec_consistent%0d", k), 32'(ok), 1);
      if (k == 2) begin
        for (int c = 0; c < 10; c++) begin
          tick();
          check_eq("stall_valid", 32'(guess_valid), 1);
          check_eq("stall_guess", 32'(guess_w), 32'(exp_g[2]));
        end
      end
      score(guess_w, secret, b, w);
      hist_g[k] = guess_w;
      hist_b[k] = b;
      hist_w[k] = w;
      accept();
      give_fb(b, w);
      n_guesses++;
      if (b == 4) break;
    end
    check_eq("sec_solved", 32'(solved), 1);
    check_eq("sec_busy", 32'(busy), 0);
    check_eq("sec_count", 32'(n_guesses), 7);
    check_eq("sec_final_turn", 32'(turn), 6);

    // Impossible feedback exhausts the candidate space
    pulse_start();
    wait_offer("exh_offer", 10);
    check_eq("exh_guess0", 32'(guess_w), 0);
    accept();
    give_fb(3, 1);
    n = 0;
    while (!failed && n < 4100) begin
      tick();
      n++;
    end
    check_eq("exh_failed", 32'(failed), 1);
    check_eq("exh_busy", 32'(busy), 0);
    check_eq("exh_guess", 32'(guess_w), 0);
    check_eq("exh_turn", 32'(turn), 1);

    // Start wins over simultaneous feedback
    pulse_start();
    check_eq("sf_failed_clr", 32'(failed), 0);
    wait_offer("sf_offer", 10);
    accept();
    start = 1'b1;
    fb_valid = 1'b1;
    tick();
    start = 1'b0;
    fb_valid = 1'b0;
    check_eq("sf_turn", 32'(turn), 0);
    check_eq("sf_hist", 32'(dut.hist_vld_q), 0);
    tick();
    check_eq("sf_valid", 32'(guess_valid), 1);
    check_eq("sf_guess", 32'(guess_w), 0);

    // Asynchronous reset in the middle of a long search
    accept();
    give_fb(1, 0);
    wait_offer("mr_offer", 200);
    check_eq("mr_guess", 32'(guess_w), 32'(mk(1, 1, 1, 0)));
    accept();
    give_fb(3, 1);
    repeat (20) tick();
    check_eq("mr_busy", 32'(busy), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("mr_valid", 32'(guess_valid), 0);
    check_eq("mr_guess0", 32'(guess_w), 0);
    check_eq("mr_turn", 32'(turn), 0);
    check_eq("mr_busy0", 32'(busy), 0);
    check_eq("mr_flags", 32'({solved, failed}), 0);
    check_eq("mr_state", 32'(dut.state_q), 32'(StIdle));
    check_eq("mr_hist", 32'(dut.hist_vld_q), 0);
    tick();
    reset_n = 1'b1;
    repeat (2) tick();
    check_eq("mr_idle", 32'(dut.state_q), 32'(StIdle));
    guess_ready = 1'b1;
    pulse_start();
    check_eq("mr_s1_valid", 32'(guess_valid), 0);
    tick();
    check_eq("mr_s2_valid", 32'(guess_valid), 1);
    check_eq("mr_s2_guess", 32'(guess_w), 0);
    guess_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/code_breaker.md
CODE_BREAKER -- requirements
Module: code_breaker

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port start, input, 1 bit: one-cycle pulse that begins a new solve.
REQ-004 SHALL have port guess_valid, output, 1 bit: guess0..guess3 hold an offered guess.
REQ-005 SHALL have port guess_ready, input, 1 bit: consumer accepts the guess.
REQ-006 SHALL have ports guess0..guess3, output, 3 bits each: colour per LED position, 0-7.
REQ-007 SHALL have port fb_valid, input, 1 bit: feedback for the last accepted guess is present.
REQ-008 SHALL have ports fb_black and fb_white, input, 3 bits each: exact-position count and colour-only count, 0-4.
REQ-009 SHALL have port turn, output, 3 bits: count of guesses scored so far, 0-7.
REQ-010 SHALL have ports busy, solved and failed, output, 1 bit each: status flags.

Function
REQ-011 SHALL implement FSM states IDLE, SEARCH, OFFER, WAIT_FB, SOLVED and FAILED.
REQ-012 SHALL map the 12-bit candidate counter cand to guess0=cand[2:0], guess1=cand[5:3], guess2=cand[8:6] and guess3=cand[11:9].
REQ-013 SHALL, on start in any state, clear the history, set turn=0 and cand=0, clear solved and failed, and enter SEARCH; start SHALL win over a simultaneous fb_valid.
REQ-014 SHALL, in each SEARCH cycle, test one candidate against every stored history entry (index < turn) in parallel.
REQ-015 SHALL treat a candidate as consistent when, for every stored entry, the recomputed black and white counts equal the stored ones.
REQ-016 SHALL compute black as the number of equal positions, and white as the sum over colours of min(count in A, count in B) minus black.
REQ-017 SHALL, when the candidate is consistent, latch it onto guess0..3 and enter OFFER on the next cycle.
REQ-018 SHALL, when the candidate is inconsistent, increment cand.
REQ-019 SHALL, when cand=4095 and the candidate is inconsistent, enter FAILED.
REQ-020 SHALL assert guess_valid only in OFFER, and SHALL hold guess0..3 stable while guess_valid=1 and guess_ready=0.
REQ-021 SHALL, on guess_valid and guess_ready both high, enter WAIT_FB, with guess_valid low from the next cycle.
REQ-022 SHALL ignore fb_valid outside WAIT_FB.
REQ-023 SHALL, on fb_valid in WAIT_FB with fb_black=4, enter SOLVED.
REQ-024 SHALL, on other fb_valid in WAIT_FB, store (guess, fb_black, fb_white) at index turn.
REQ-025 SHALL, after a REQ-024 store with turn=7, enter FAILED.
REQ-026 SHALL, after a REQ-024 store with turn<7, increment turn and cand and re-enter SEARCH.
REQ-027 SHALL store illegal feedback (black+white>4, or black=3 with white=1) unchanged; no candidate matches it, so the search runs to FAILED.
REQ-028 SHALL assert busy in SEARCH, OFFER and WAIT_FB.
REQ-029 SHALL hold solved and failed at 1 until the next start or reset.
REQ-030 SHALL keep guess0..3 at the last offered guess in SOLVED and FAILED.
REQ-031 SHALL, with empty history, make candidate 0 (0,0,0,0) consistent, giving guess_valid 2 cycles after start.

Reset
REQ-032 SHALL, while reset_n=0, immediately force state IDLE, cand=0, turn=0, guess0..3=0, guess_valid=0, busy=0, solved=0 and failed=0, and clear all history valid bits, including mid-search.
REQ-033 SHALL remain in IDLE after reset release until start.

Structure
REQ-034 SHALL take CODE_LEN=4, COLOR_W=3, MAX_TURNS=8 and the FSM state encoding from the shared mastermind package.
REQ-035 SHALL put scoring in one combinational sub-module, peg_score (two codes in, black and white out), instantiated MAX_TURNS times.
REQ-036 SHALL hold history in a register array of MAX_TURNS entries of 12+3+3 bits, with no RAM.

Verification
REQ-037 SHALL cover: reset -> all outputs 0 and state IDLE; start with guess_ready=1 -> guess (0,0,0,0) valid 2 cycles later; fb black=4 -> solved=1, busy=0.
REQ-038 SHALL cover: bench-scored secret (1,2,3,4) -> solved within 8 turns, with every offered guess consistent with all prior feedback.
REQ-039 SHALL cover: guess_ready held 0 for 10 cycles in OFFER -> guess_valid stays 1 and guess0..3 unchanged.
REQ-040 SHALL cover: feedback black=3 white=1 on the first guess -> search exhausts cand=4095 -> failed=1 within 4100 cycles.
REQ-041 SHALL cover: start coincident with fb_valid in WAIT_FB -> history cleared, turn=0, new guess (0,0,0,0).
REQ-042 SHALL cover: reset_n pulsed low mid-SEARCH -> outputs zero in the same cycle; start after release behaves as in REQ-037.
